// File: rtl/if_pkg.sv
// Shared types and constants for the RV32 instruction-fetch stage.
package if_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    BUF   = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid_inst;
  } if_id_reg_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } hold_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/if_hold_buf.sv
// One-entry holding buffer for a fetched {inst, pc} that arrived while decode stalled.
module if_hold_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] inst_in,
  input  logic [31:0] pc_in,
  output logic        full,
  output logic [31:0] inst,
  output logic [31:0] pc
);

  logic        full_q, full_d;
  hold_entry_t entry_q, entry_d;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d  = 1'b1;
      entry_d = '{inst: inst_in, pc: pc_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full = full_q;
  assign inst = entry_q.inst;
  assign pc   = entry_q.pc;

endmodule

// File: rtl/if_fetch_unit.sv
// RV32 IF stage: single-outstanding imem fetch feeding the IF/ID register.
// Optional IF_PERF_CNT_EN adds fetch_count / stall_cycles outputs.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = if_pkg::NOP_INST
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   take_branch,
  input  logic [31:0]            branch_target,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            if_id_IR,
  output logic [31:0]            if_id_PC,
  output logic [31:0]            if_id_NPC,
  output logic                   if_id_valid_inst
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]            fetch_count,
  output logic [31:0]            stall_cycles
`endif
);
  import if_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  if_id_reg_t   if_id_q, if_id_d;
  logic         if_id_load;
  logic         req_c;
  logic         buf_load, buf_clear, buf_full;
  logic [31:0]  buf_inst, buf_pc;
  logic [31:0]  redirect_pc;

  assign redirect_pc = branch_target & 32'hFFFF_FFFC;

  if_hold_buf u_hold_buf (
    .clk     (clk),
    .rst     (rst),
    .load    (buf_load),
    .clear   (buf_clear),
    .inst_in (imem.imem_rdata),
    .pc_in   (pc_q),
    .full    (buf_full),
    .inst    (buf_inst),
    .pc      (buf_pc)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_id_d    = if_id_q;
    if_id_load = 1'b0;
    req_c      = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;

    // With decode free and nothing to hand over, a bubble is inserted.
    if (!stall) begin
      if_id_d.ir         = NOP_INST;
      if_id_d.valid_inst = 1'b0;
    end

    case (state_q)
      FETCH: begin
        req_c = !take_branch;
        if (req_c && imem.imem_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (!stall) begin
            if_id_d    = '{ir: imem.imem_rdata, pc: pc_q, npc: pc_q + 32'd4, valid_inst: 1'b1};
            if_id_load = 1'b1;
            pc_d       = pc_q + 32'd4;
            state_d    = FETCH;
          end else begin
            buf_load = 1'b1;
            state_d  = BUF;
          end
        end
      end
      BUF: begin
        if (!stall && buf_full) begin
          if_id_d    = '{ir: buf_inst, pc: buf_pc, npc: buf_pc + 32'd4, valid_inst: 1'b1};
          if_id_load = 1'b1;
          pc_d       = pc_q + 32'd4;
          buf_clear  = 1'b1;
          state_d    = FETCH;
        end
      end
      DROP: begin
        if (imem.imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Redirect wins over everything, stall included. A response still in
    // flight must be swallowed, hence DROP when it has not arrived yet.
    if (take_branch) begin
      pc_d               = redirect_pc;
      if_id_d            = if_id_q;
      if_id_d.ir         = NOP_INST;
      if_id_d.valid_inst = 1'b0;
      if_id_load         = 1'b0;
      buf_load           = 1'b0;
      buf_clear          = 1'b1;
      if ((state_q == WAIT || state_q == DROP) && !imem.imem_rvalid) state_d = DROP;
      else                                                           state_d = FETCH;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      if_id_q <= '{ir: NOP_INST, pc: 32'd0, npc: 32'd0, valid_inst: 1'b0};
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if_id_q <= if_id_d;
    end
  end

  assign imem.imem_req  = req_c & rst;
  assign imem.imem_addr = pc_q;

  assign if_id_IR         = if_id_q.ir;
  assign if_id_PC         = if_id_q.pc;
  assign if_id_NPC        = if_id_q.npc;
  assign if_id_valid_inst = if_id_q.valid_inst;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    fetch_count_d  = fetch_count_q + {31'd0, if_id_load};
    stall_cycles_d = stall_cycles_q + {31'd0, stall};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count_q  <= 32'd0;
      stall_cycles_q <= 32'd0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign stall_cycles = stall_cycles_q;
`endif

endmodule
